fp16_normalizer: RTL and testbench

- Post-addition normalizer for the FP16 adder path, the inverse of the pre-add alignment step.
- Alignment right-shifts the smaller significand so exponents match; this block takes the raw significand sum and restores the hidden bit.
  - Carry-out: right shift by 1.
  - Cancellation: leading-zero count, then left shift.
- Adjusts the exponent, handles zero/overflow/underflow, and packs an FP16 result.
- Two-stage pipeline with valid/ready handshakes on both sides; sits between the significand adder and the result register.

---
 rtl/fp16_normalizer_if.sv | 27 ++
 rtl/fp16_normalizer.sv | 161 ++++++++++++++++
 tb/tb_fp16_normalizer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp16_normalizer_if.sv
// Valid/ready bus between the significand adder, the FP16 normalizer and the result register.
// The slave modport is the normalizer's view; the master modport is the producer/consumer side.
interface fp16_normalizer_if #(
    parameter int EXP_W  = 5,
    parameter int FRAC_W = 10
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sign;
    logic [EXP_W-1:0]        in_exp;
    logic [FRAC_W+3:0]       in_mant;
    logic                    out_valid;
    logic                    out_ready;
    logic [EXP_W+FRAC_W:0]   out_result;
    logic                    out_overflow;
    logic                    out_underflow;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_underflow
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, out_result, out_overflow, out_underflow
    );
endinterface

// File: rtl/fp16_normalizer.sv
// Two-stage post-addition FP16 normalizer: carry right-shift or LZC left-shift, exponent fix-up, packing.
// Define FP16_NORM_ROUND_NEAREST_EN for round-to-nearest-even; otherwise the result is truncated.
module fp16_normalizer #(
    parameter int EXP_W  = 5,
    parameter int FRAC_W = 10
) (
    input logic              clk,
    input logic              rst,
    fp16_normalizer_if.slave bus
);
    localparam int MANT_W = FRAC_W + 4;
    localparam int SIG_W  = FRAC_W + 3;
    localparam int LZ_W   = $clog2(SIG_W + 1);
    localparam int E6_W   = EXP_W + 1;
    localparam int RES_W  = EXP_W + FRAC_W + 1;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    logic s1_adv;
    logic s2_adv;

    logic              s1_valid_q;
    logic              s1_sign_q;
    logic [EXP_W-1:0]  s1_exp_q;
    logic [MANT_W-1:0] s1_mant_q;
    logic              s1_carry_q;
    logic [LZ_W-1:0]   s1_lz_q;
    logic              s1_zero_q;

    logic [LZ_W-1:0]   lz_d;
    logic              lz_found;

    logic              s2_valid_q;
    logic [RES_W-1:0]  s2_result_q;
    logic              s2_ovf_q;
    logic              s2_unf_q;

    logic [RES_W-1:0]  s2_result_d;
    logic              s2_ovf_d;
    logic              s2_unf_d;

    logic [SIG_W-1:0]  sig;
    logic [E6_W-1:0]   exp_in;
    logic [E6_W-1:0]   exp_n;
    logic [FRAC_W-1:0] frac;
    logic              norm_ok;
`ifdef FP16_NORM_ROUND_NEAREST_EN
    logic [FRAC_W:0]   frac_inc;
`else
    logic              unused_guard_sticky;
`endif

    assign s2_adv       = !s2_valid_q || bus.out_ready;
    assign s1_adv       = !s1_valid_q || s2_adv;
    assign bus.in_ready = s1_adv;

    always_comb begin
        lz_d     = LZ_W'(SIG_W);
        lz_found = 1'b0;
        for (int unsigned i = 0; i < SIG_W; i++) begin
            if (!lz_found && bus.in_mant[SIG_W-1-i]) begin
                lz_d     = LZ_W'(i);
                lz_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_mant_q  <= '0;
            s1_carry_q <= 1'b0;
            s1_lz_q    <= '0;
            s1_zero_q  <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= bus.in_valid;
            s1_sign_q  <= bus.in_sign;
            s1_exp_q   <= bus.in_exp;
            s1_mant_q  <= bus.in_mant;
            s1_carry_q <= bus.in_mant[MANT_W-1];
            s1_lz_q    <= lz_d;
            s1_zero_q  <= (bus.in_mant == '0);
        end
    end

    // Priority: saturated input, exact zero, carry renormalize, cancellation renormalize/underflow.
    always_comb begin
        s2_result_d = '0;
        s2_ovf_d    = 1'b0;
        s2_unf_d    = 1'b0;
        sig         = '0;
        exp_in      = {1'b0, s1_exp_q};
        exp_n       = '0;
        frac        = '0;
        norm_ok     = 1'b0;
`ifdef FP16_NORM_ROUND_NEAREST_EN
        frac_inc    = '0;
`endif
        if (s1_exp_q == EXP_MAX) begin
            s2_result_d = {s1_sign_q, EXP_MAX, {FRAC_W{1'b0}}};
            s2_ovf_d    = 1'b1;
        end else if (s1_zero_q) begin
            s2_result_d = '0;
        end else if (s1_carry_q) begin
            sig     = {s1_mant_q[MANT_W-1:2], s1_mant_q[1] | s1_mant_q[0]};
            exp_n   = exp_in + E6_W'(1);
            norm_ok = 1'b1;
        end else if (exp_in <= E6_W'(s1_lz_q)) begin
            s2_unf_d = 1'b1;
        end else begin
            sig     = s1_mant_q[SIG_W-1:0] << s1_lz_q;
            exp_n   = exp_in - E6_W'(s1_lz_q);
            norm_ok = 1'b1;
        end

        if (norm_ok) begin
            frac = sig[FRAC_W+1:2];
`ifdef FP16_NORM_ROUND_NEAREST_EN
            if (sig[1] && (sig[0] || frac[0])) begin
                frac_inc = {1'b0, frac} + (FRAC_W+1)'(1);
                frac     = frac_inc[FRAC_W-1:0];
                if (frac_inc[FRAC_W]) begin
                    exp_n = exp_n + E6_W'(1);
                end
            end
`endif
            if (exp_n >= E6_W'(EXP_MAX)) begin
                s2_result_d = {s1_sign_q, EXP_MAX, {FRAC_W{1'b0}}};
                s2_ovf_d    = 1'b1;
            end else begin
                s2_result_d = {s1_sign_q, exp_n[EXP_W-1:0], frac};
            end
        end
    end

`ifndef FP16_NORM_ROUND_NEAREST_EN
    assign unused_guard_sticky = ^sig[1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_ovf_q    <= 1'b0;
            s2_unf_q    <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_result_q <= s2_result_d;
                s2_ovf_q    <= s2_ovf_d;
                s2_unf_q    <= s2_unf_d;
            end
        end
    end

    assign bus.out_valid     = s2_valid_q;
    assign bus.out_result    = s2_result_q;
    assign bus.out_overflow  = s2_ovf_q;
    assign bus.out_underflow = s2_unf_q;
endmodule

// File: tb/tb_fp16_normalizer.sv
// Self-checking bench for fp16_normalizer: value-level reference model plus pinned literal vectors.
// Honors FP16_NORM_ROUND_NEAREST_EN the same way as the design build.
module tb_fp16_normalizer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rand_rdy = 1'b0;
    logic rnd_bit  = 1'b1;
    logic rdy_tb   = 1'b1;

    int checks = 0;
    int passes = 0;
    int n_out  = 0;

    logic [17:0] exp_q[$];
    logic        hold_v = 1'b0;
    logic [17:0] hold_val = '0;

    typedef struct {
        logic        s;
        logic [4:0]  e;
        logic [13:0] m;
    } vec_t;
    vec_t vt[$];

    fp16_normalizer_if #(.EXP_W(5), .FRAC_W(10)) ifc ();

    fp16_normalizer #(.EXP_W(5), .FRAC_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
    assign ifc.out_ready = rand_rdy ? rnd_bit : rdy_tb;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got === expv) passes++;
        else $display("FAIL %s: got %h expected %h", name, got, expv);
    endtask

    // Value-level reference: {overflow, underflow, result}
    function automatic logic [17:0] model(input logic s, input logic [4:0] e, input logic [13:0] m);
        int p, ex, n, frac, rest;
        if (e == 5'd31) return {2'b10, s, 5'h1F, 10'h000};
        if (m == 14'd0) return 18'd0;
        p = 13;
        while (((int'(m) >> p) & 1) == 0) p--;
        ex = int'(e) + p - 12;
        if (ex <= 0) return {2'b01, 16'h0000};
        n = int'(m);
        if (p == 13) n = (n >> 1) | (n & 1);
        else n = n << (12 - p);
        frac = (n >> 2) & 1023;
        rest = n & 3;
`ifdef FP16_NORM_ROUND_NEAREST_EN
        if (rest > 2 || (rest == 2 && (frac % 2) == 1)) begin
            frac++;
            if (frac == 1024) begin
                frac = 0;
                ex++;
            end
        end
`else
        if (rest < 0) frac = 0;
`endif
        if (ex >= 31) return {2'b10, s, 5'h1F, 10'h000};
        return {2'b00, s, 5'(ex), 10'(frac)};
    endfunction

    always @(negedge clk) begin
        logic [17:0] got, e;
        got = {ifc.out_overflow, ifc.out_underflow, ifc.out_result};
        if (rst) begin
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            if (ifc.out_valid) begin
                if (hold_v) check("hold_stable", 32'(got), 32'(hold_val));
                if (ifc.out_ready) begin
                    n_out++;
                    if (exp_q.size() == 0) check("unexpected_out", 32'(exp_q.size()), 32'd1);
                    else begin
                        e = exp_q.pop_front();
                        check("model", 32'(got), 32'(e));
                    end
                    hold_v = 1'b0;
                end else begin
                    hold_v   = 1'b1;
                    hold_val = got;
                end
            end else begin
                hold_v = 1'b0;
            end
            if (ifc.in_valid && ifc.in_ready)
                exp_q.push_back(model(ifc.in_sign, ifc.in_exp, ifc.in_mant));
        end
    end

    task automatic drive(input logic s, input logic [4:0] e, input logic [13:0] m);
        ifc.in_valid = 1'b1;
        ifc.in_sign  = s;
        ifc.in_exp   = e;
        ifc.in_mant  = m;
    endtask

    task automatic send(input logic s, input logic [4:0] e, input logic [13:0] m);
        drive(s, e, m);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ifc.in_ready) begin
                @(posedge clk);
                #1;
                ifc.in_valid = 1'b0;
                return;
            end
        end
        check("send_timeout", 32'(ifc.in_ready), 32'd1);
        ifc.in_valid = 1'b0;
    endtask

    task automatic pin(input string name, input logic s, input logic [4:0] e,
                       input logic [13:0] m, input logic [17:0] expv);
        @(posedge clk);
        #1;
        drive(s, e, m);
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_valid"}, 32'(ifc.out_valid), 32'd1);
        check(name, 32'({ifc.out_overflow, ifc.out_underflow, ifc.out_result}), 32'(expv));
    endtask

    initial begin
        int idx, outs0;
        vec_t bp[3];
        logic [17:0] rnd_exp;

        ifc.in_valid = 1'b0;
        ifc.in_sign  = 1'b0;
        ifc.in_exp   = '0;
        ifc.in_mant  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_in_ready", 32'(ifc.in_ready), 32'd1);
        check("rst_result", 32'(ifc.out_result), 32'h0000);
        check("rst_flags", 32'({ifc.out_overflow, ifc.out_underflow}), 32'd0);
        rst = 1'b0;

        pin("carry", 1'b0, 5'd15, 14'h2000, {2'b00, 16'h4000});
        pin("cancel", 1'b0, 5'd15, 14'h0100, {2'b00, 16'h2C00});
        pin("underflow", 1'b0, 5'd3, 14'h0100, {2'b01, 16'h0000});
        pin("zero", 1'b1, 5'd20, 14'h0000, {2'b00, 16'h0000});
        pin("overflow", 1'b0, 5'd30, 14'h2000, {2'b10, 16'h7C00});
        pin("exp31", 1'b1, 5'd31, 14'h0123, {2'b10, 16'hFC00});
        pin("lz_eq_exp", 1'b0, 5'd12, 14'h0001, {2'b01, 16'h0000});
        pin("lz_lt_exp", 1'b1, 5'd13, 14'h0001, {2'b00, 16'h8400});
`ifdef FP16_NORM_ROUND_NEAREST_EN
        rnd_exp = {2'b00, 16'h4000};
`else
        rnd_exp = {2'b00, 16'h3FFF};
`endif
        pin("round", 1'b0, 5'd15, 14'h1FFF, rnd_exp);

        vt.push_back('{1'b0, 5'd15, 14'h2000});
        vt.push_back('{1'b1, 5'd15, 14'h2007});
        vt.push_back('{1'b0, 5'd15, 14'h1FFF});
        vt.push_back('{1'b1, 5'd10, 14'h0001});
        vt.push_back('{1'b0, 5'd13, 14'h0001});
        vt.push_back('{1'b0, 5'd5,  14'h0800});
        vt.push_back('{1'b0, 5'd0,  14'h1000});
        vt.push_back('{1'b1, 5'd0,  14'h2000});
        vt.push_back('{1'b0, 5'd30, 14'h1FFF});
        vt.push_back('{1'b1, 5'd31, 14'h0000});
        vt.push_back('{1'b0, 5'd29, 14'h3FFE});
        vt.push_back('{1'b1, 5'd20, 14'h0000});
        vt.push_back('{1'b1, 5'd7,  14'h0155});
        vt.push_back('{1'b0, 5'd30, 14'h1FFE});
        vt.push_back('{1'b0, 5'd9,  14'h0006});
        vt.push_back('{1'b1, 5'd22, 14'h1ABE});

        @(posedge clk);
        #1;
        foreach (vt[i]) send(vt[i].s, vt[i].e, vt[i].m);
        rand_rdy = 1'b1;
        for (int r = 0; r < 3; r++)
            foreach (vt[i]) send(vt[i].s, vt[i].e, vt[i].m);
        rand_rdy = 1'b0;
        rdy_tb   = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        bp[0] = '{1'b0, 5'd15, 14'h2000};
        bp[1] = '{1'b1, 5'd15, 14'h0100};
        bp[2] = '{1'b0, 5'd7,  14'h0155};
        outs0 = n_out;
        rdy_tb = 1'b0;
        idx = 0;
        drive(bp[0].s, bp[0].e, bp[0].m);
        for (int c = 0; c < 12; c++) begin
            if (c == 6) begin
                check("bp_accepts", 32'(idx), 32'd2);
                check("bp_in_ready", 32'(ifc.in_ready), 32'd0);
                check("bp_out_valid", 32'(ifc.out_valid), 32'd1);
                check("bp_head", 32'(ifc.out_result), 32'h4000);
                rdy_tb = 1'b1;
            end
            @(negedge clk);
            if (ifc.in_valid && ifc.in_ready) idx++;
            @(posedge clk);
            #1;
            if (idx < 3) drive(bp[idx].s, bp[idx].e, bp[idx].m);
            else ifc.in_valid = 1'b0;
        end
        check("bp_total_accepts", 32'(idx), 32'd3);
        check("bp_total_outs", 32'(n_out - outs0), 32'd3);

        rdy_tb = 1'b0;
        send(1'b0, 5'd15, 14'h2000);
        send(1'b1, 5'd16, 14'h0400);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_mid_in_ready", 32'(ifc.in_ready), 32'd1);
        outs0  = n_out;
        rdy_tb = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("rst_mid_no_out", 32'(n_out - outs0), 32'd0);
        check("drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
